// File: rtl/shift_word_transmitter.sv
// shift_word_transmitter
//   Serializer for the I2C read-data path. A word is accepted into a
//   one-entry holding buffer through a valid/ready port. It is shifted out
//   one bit per shift_en strobe, MSB- or LSB-first, and is optionally
//   followed by an acknowledge slot. Buffered words chain back-to-back.
//
// Ports
//   clk, reset        clock, synchronous active-low reset
//   abort             synchronous flush to IDLE (drops any buffered word)
//   load_valid/_data  word offered for transmission
//   load_ready        holding buffer empty
//   shift_en          advance the line by one bit (SCL falling edge)
//   ack_sample/ack_in sample the acknowledge bit (SCL rising edge)
//   out               serial bit to the SDA driver (registered)
//   busy              a word is in SHIFT or ACK
//   bit_index         send-order index of the bit currently on out
//   word_done         one-cycle pulse when a word (plus ACK slot) completes
//   nack              result of the last completed word (1 = NACK/unsampled)
module shift_word_transmitter #(
    parameter int WIDTH      = 8,
    parameter int MSB_FIRST  = 1,
    parameter int ACK_SLOT   = 1,
    parameter int IDLE_LEVEL = 1,
    localparam int BW = ($clog2(WIDTH) < 1) ? 1 : $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             abort,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    input  logic             shift_en,
    input  logic             ack_sample,
    input  logic             ack_in,
    output logic             out,
    output logic             busy,
    output logic [BW-1:0]    bit_index,
    output logic             word_done,
    output logic             nack
);

    localparam logic          IDLE_BIT = (IDLE_LEVEL != 0);
    localparam logic          HAS_ACK  = (ACK_SLOT != 0);
    localparam logic [BW-1:0] LAST     = BW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, ACK} state_t;

    state_t           state;
    logic [WIDTH-1:0] hold;
    logic             hold_valid;
    logic [WIDTH-1:0] sh;
    logic [BW-1:0]    cnt;
    logic             ack_bit;

    logic last_bit;
    logic finish;
    logic start;
    logic first_bit;

    assign last_bit  = (cnt == LAST);
    // Word completes on the final data strobe (no ACK slot) or the strobe
    // that closes the ACK slot.
    assign finish    = shift_en && ((state == SHIFT && last_bit && !HAS_ACK) ||
                                    (state == ACK));
    // Buffered word moves into the shifter from IDLE, or on the same edge
    // that finishes the previous word so there is no idle gap.
    assign start     = hold_valid && (state == IDLE || finish);
    assign first_bit = (MSB_FIRST != 0) ? hold[WIDTH-1] : hold[0];

    assign load_ready = !hold_valid;
    assign busy       = (state != IDLE);
    assign bit_index  = cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            hold       <= '0;
            hold_valid <= 1'b0;
            sh         <= '0;
            cnt        <= '0;
            ack_bit    <= 1'b1;
            out        <= IDLE_BIT;
            word_done  <= 1'b0;
            nack       <= 1'b0;
        end else if (abort) begin
            // A load offered in this cycle is dropped along with the buffer.
            state      <= IDLE;
            hold_valid <= 1'b0;
            cnt        <= '0;
            out        <= IDLE_BIT;
            word_done  <= 1'b0;
        end else begin
            word_done <= 1'b0;

            // start only fires with hold_valid set, accept only with it clear,
            // so the two never touch hold_valid in the same cycle.
            if (load_valid && !hold_valid) begin
                hold       <= load_data;
                hold_valid <= 1'b1;
            end

            if (finish) begin
                word_done <= 1'b1;
                if (state == ACK)
                    nack <= ack_sample ? ack_in : ack_bit;
                else
                    nack <= 1'b0;
            end

            if (start) begin
                sh         <= hold;
                hold_valid <= 1'b0;
                cnt        <= '0;
                ack_bit    <= 1'b1;
                out        <= first_bit;
                state      <= SHIFT;
            end else if (finish) begin
                state <= IDLE;
                cnt   <= '0;
                out   <= IDLE_BIT;
            end else begin
                case (state)
                    SHIFT: if (shift_en) begin
                        if (!last_bit) begin
                            cnt <= cnt + 1'b1;
                            if (MSB_FIRST != 0) begin
                                sh  <= {sh[WIDTH-2:0], 1'b0};
                                out <= sh[WIDTH-2];
                            end else begin
                                sh  <= {1'b0, sh[WIDTH-1:1]};
                                out <= sh[1];
                            end
                        end else begin
                            // Only reached with an ACK slot; the no-slot
                            // case is handled by finish.
                            state <= ACK;
                            out   <= IDLE_BIT;
                        end
                    end
                    ACK: if (ack_sample) ack_bit <= ack_in;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shift_word_transmitter.sv
// Directed bench: an 8-bit MSB-first ACK instance and a 4-bit LSB-first
// no-ACK instance, sharing clock and reset.
module tb_shift_word_transmitter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       abort = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = '0;
    logic       load_ready, shift_en = 1'b0, ack_sample = 1'b0, ack_in = 1'b0;
    logic       out, busy, word_done, nack;
    logic [2:0] bit_index;

    logic       l4_valid = 1'b0, l4_ready, s4 = 1'b0;
    logic [3:0] l4_data = '0;
    logic       o4, busy4, wd4, nack4;
    logic [1:0] bi4;

    int n_chk = 0, n_pass = 0;
    int wd8 = 0, wd4n = 0;

    always #5 clk = ~clk;

    shift_word_transmitter dut (
        .clk(clk), .reset(reset), .abort(abort),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .shift_en(shift_en), .ack_sample(ack_sample), .ack_in(ack_in),
        .out(out), .busy(busy), .bit_index(bit_index),
        .word_done(word_done), .nack(nack)
    );

    shift_word_transmitter #(.WIDTH(4), .MSB_FIRST(0), .ACK_SLOT(0)) dut4 (
        .clk(clk), .reset(reset), .abort(1'b0),
        .load_valid(l4_valid), .load_data(l4_data), .load_ready(l4_ready),
        .shift_en(s4), .ack_sample(1'b0), .ack_in(1'b0),
        .out(o4), .busy(busy4), .bit_index(bi4),
        .word_done(wd4), .nack(nack4)
    );

    always @(posedge clk) begin
        if (word_done) wd8++;
        if (wd4) wd4n++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic load8(input logic [7:0] d);
        load_valid = 1'b1; load_data = d;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic strobe();
        shift_en = 1'b1;
        tick();
        shift_en = 1'b0;
    endtask

    task automatic gap();
        repeat (3) tick();
    endtask

    task automatic ack_pulse(input logic v);
        ack_in = v; ack_sample = 1'b1;
        tick();
        ack_sample = 1'b0;
    endtask

    // Strobes 1..7 present bits 6..0 (MSB-first); strobe 8 releases the line.
    task automatic shift_bits(input string tag, input logic [7:0] w);
        for (int i = 0; i < 7; i++) begin
            strobe();
            chk($sformatf("%s_bit%0d", tag, i + 1), 32'(out), 32'(w[6-i]));
            chk($sformatf("%s_idx%0d", tag, i + 1), 32'(bit_index), i + 1);
            gap();
        end
        strobe();
        chk({tag, "_ackrel"}, 32'(out), 1);
        chk({tag, "_ackbusy"}, 32'(busy), 1);
        gap();
    endtask

    initial begin
        logic [3:0] w4;
        tick(); tick();
        reset = 1'b1;

        // reset state
        chk("rst_out", 32'(out), 1);
        chk("rst_ready", 32'(load_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_idx", 32'(bit_index), 0);
        chk("rst_done", 32'(word_done), 0);
        chk("rst_nack", 32'(nack), 0);

        // LSB-first, no ACK slot: 0x6 -> 0,1,1,0
        w4 = 4'h6;
        l4_valid = 1'b1; l4_data = w4;
        tick();
        l4_valid = 1'b0;
        tick();
        chk("lsb_first", 32'(o4), 0);
        chk("lsb_busy", 32'(busy4), 1);
        for (int i = 1; i < 4; i++) begin
            s4 = 1'b1; tick(); s4 = 1'b0;
            chk($sformatf("lsb_bit%0d", i), 32'(o4), 32'(w4[i]));
            gap();
        end
        s4 = 1'b1; tick(); s4 = 1'b0;
        chk("lsb_done", 32'(wd4), 1);
        chk("lsb_nack", 32'(nack4), 0);
        chk("lsb_idle", 32'(busy4), 0);
        chk("lsb_out_idle", 32'(o4), 1);
        tick();
        chk("lsb_done_low", 32'(wd4), 0);

        // MSB-first 0xA5 with ACK
        load8(8'hA5);
        chk("a5_held_ready", 32'(load_ready), 0);
        chk("a5_held_busy", 32'(busy), 0);
        tick();
        chk("a5_busy", 32'(busy), 1);
        chk("a5_bit0", 32'(out), 1);
        chk("a5_idx0", 32'(bit_index), 0);
        chk("a5_ready_back", 32'(load_ready), 1);
        gap();
        shift_bits("a5", 8'hA5);
        ack_pulse(1'b0);
        strobe();
        chk("a5_done", 32'(word_done), 1);
        chk("a5_nack", 32'(nack), 0);
        chk("a5_idle", 32'(busy), 0);
        chk("a5_out_idle", 32'(out), 1);
        tick();
        chk("a5_done_low", 32'(word_done), 0);

        // back-to-back 0x81 then 0x7E
        load8(8'h81);
        tick();
        chk("b2b_81_bit0", 32'(out), 1);
        load8(8'h7E);
        chk("b2b_ready_lo", 32'(load_ready), 0);
        shift_bits("x81", 8'h81);
        chk("b2b_ready_lo2", 32'(load_ready), 0);
        ack_pulse(1'b0);
        strobe();
        chk("b2b_done1", 32'(word_done), 1);
        chk("b2b_nack1", 32'(nack), 0);
        chk("b2b_7e_bit0", 32'(out), 0);
        chk("b2b_busy", 32'(busy), 1);
        chk("b2b_idx0", 32'(bit_index), 0);
        chk("b2b_ready_hi", 32'(load_ready), 1);
        gap();
        shift_bits("x7e", 8'h7E);
        // collision: earlier ACK sample, then ack_in=1 sampled with the
        // closing strobe must win
        ack_pulse(1'b0);
        ack_in = 1'b1; ack_sample = 1'b1; shift_en = 1'b1;
        tick();
        ack_sample = 1'b0; shift_en = 1'b0;
        chk("coll_nack", 32'(nack), 1);
        chk("coll_done", 32'(word_done), 1);
        chk("coll_idle", 32'(busy), 0);
        tick();

        // abort after 3 bits of 0xFF with 0x55 buffered
        load8(8'hFF);
        tick();
        repeat (3) begin strobe(); gap(); end
        chk("ab_idx3", 32'(bit_index), 3);
        load8(8'h55);
        chk("ab_buffered", 32'(load_ready), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_busy", 32'(busy), 0);
        chk("ab_out", 32'(out), 1);
        chk("ab_ready", 32'(load_ready), 1);
        chk("ab_idx", 32'(bit_index), 0);
        chk("ab_nodone", 32'(word_done), 0);
        chk("ab_nack_hold", 32'(nack), 1);
        tick();
        chk("ab_flushed", 32'(busy), 0);
        strobe();
        chk("ab_strobe_out", 32'(out), 1);
        chk("ab_strobe_busy", 32'(busy), 0);
        load_valid = 1'b1; load_data = 8'h55; abort = 1'b1;
        tick();
        load_valid = 1'b0; abort = 1'b0;
        chk("ab_load_drop", 32'(load_ready), 1);
        tick();
        chk("ab_load_idle", 32'(busy), 0);

        // reset during bit 5, another word buffered
        load8(8'h5A);
        tick();
        repeat (5) begin strobe(); gap(); end
        chk("rm_idx5", 32'(bit_index), 5);
        load8(8'h11);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rm_out", 32'(out), 1);
        chk("rm_ready", 32'(load_ready), 1);
        chk("rm_busy", 32'(busy), 0);
        chk("rm_idx", 32'(bit_index), 0);
        chk("rm_done", 32'(word_done), 0);
        chk("rm_nack", 32'(nack), 0);
        shift_en = 1'b1; ack_sample = 1'b1; ack_in = 1'b1;
        tick();
        shift_en = 1'b0; ack_sample = 1'b0; ack_in = 1'b0;
        chk("stray_out", 32'(out), 1);
        chk("stray_busy", 32'(busy), 0);
        chk("stray_nack", 32'(nack), 0);
        tick();
        chk("stray_idle", 32'(busy), 0);

        // last ACK sample wins: 0 then 1 -> NACK
        load8(8'h3C);
        tick();
        chk("x3c_bit0", 32'(out), 0);
        gap();
        shift_bits("x3c", 8'h3C);
        ack_pulse(1'b0);
        ack_pulse(1'b1);
        strobe();
        chk("x3c_nack", 32'(nack), 1);
        chk("x3c_done", 32'(word_done), 1);
        tick();

        // ACK word after a NACK
        load8(8'hC3);
        tick();
        chk("xc3_bit0", 32'(out), 1);
        gap();
        shift_bits("xc3", 8'hC3);
        ack_pulse(1'b0);
        strobe();
        chk("xc3_nack", 32'(nack), 0);
        tick();

        chk("done_count8", wd8, 5);
        chk("done_count4", wd4n, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/shift_word_transmitter.md
# shift_word_transmitter

Parametrised serializer for the I2C peripheral's read-data path. It accepts a word through a valid/ready load port into a one-entry holding buffer. It shifts the word out one bit per `shift_en` strobe, in MSB-first or LSB-first order, and tracks the bit count itself. It optionally runs an I2C acknowledge slot after each word, reports the ACK/NACK result, and chains buffered words back-to-back.

## Interface
- `WIDTH`, default 8: word width in bits; legal range is 2 or more.
- `MSB_FIRST`, default 1: 1 sends bit WIDTH-1 first; 0 sends bit 0 first.
- `ACK_SLOT`, default 1: 1 appends one acknowledge slot per word; 0 omits it.
- `IDLE_LEVEL`, default 1: value driven on `out` when idle and during the ACK slot (released line).
- `clk`, input, 1: clock.
- `reset`, input, 1: reset, synchronous, active-low.
- `abort`, input, 1: synchronous flush; active-high.
- `load_valid`, input, 1: `load_data` is valid.
- `load_data`, input, WIDTH: word to send.
- `load_ready`, output, 1: holding buffer is empty.
- `shift_en`, input, 1: one-cycle strobe that advances the line by one bit (driven from the SCL falling-edge detector).
- `ack_sample`, input, 1: one-cycle strobe that samples `ack_in` (driven from the SCL rising-edge detector).
- `ack_in`, input, 1: synchronized SDA input.
- `out`, output, 1: serial data bit presented to the SDA driver.
- `busy`, output, 1: state is SHIFT or ACK.
- `bit_index`, output, max(1,$clog2(WIDTH)): index, in send order, of the bit currently on `out`.
- `word_done`, output, 1: one-cycle pulse when a word, including its ACK slot, completes.
- `nack`, output, 1: result of the last completed word; 1 = NACK or not sampled, 0 = ACK.

## Operation
- States: IDLE, SHIFT, ACK. Internal registers: `hold`, `hold_valid`, shift register `sh`, counter `cnt`, `ack_bit`.
- `load_ready` = !`hold_valid`, combinational.
- Load accept (`load_valid && load_ready`): `hold` <= `load_data` and `hold_valid` <= 1 at the edge.
- IDLE with `hold_valid`:
  - `sh` <= `hold`, `hold_valid` <= 0, `cnt` <= 0, `ack_bit` <= 1.
  - `out` <= first bit (`hold[WIDTH-1]` if MSB_FIRST, else `hold[0]`).
  - Next state SHIFT.
- SHIFT with `shift_en`:
  - If `cnt` < WIDTH-1: `cnt`++, `sh` shifts toward the send end, `out` <= next bit.
  - If `cnt` == WIDTH-1 and ACK_SLOT=1: go to ACK and set `out` <= IDLE_LEVEL.
  - If `cnt` == WIDTH-1 and ACK_SLOT=0: finish.
- ACK state:
  - `ack_sample` sets `ack_bit` <= `ack_in`; the last sample wins.
  - `shift_en` finishes the word.
  - If `ack_sample` and `shift_en` occur in the same cycle, `ack_in` is captured into `nack` directly.
- Finish, at one edge:
  - `word_done` <= 1 and `nack` <= `ack_bit` (ACK_SLOT=0: `nack` <= 0).
  - If `hold_valid`: load the next word exactly as from IDLE, so the next word's first bit appears on the edge that ends the previous word. There is no idle gap.
  - Otherwise go to IDLE with `out` <= IDLE_LEVEL.
- Ignored strobes: `shift_en` in IDLE, and `ack_sample` outside ACK.
- `abort`: next edge goes to IDLE, `hold_valid` <= 0, `out` <= IDLE_LEVEL, `cnt` <= 0, and no `word_done`. A load accepted in the same cycle as `abort` is discarded. `nack` holds its value.
- `bit_index` = `cnt`.
- `busy` = (state != IDLE).

## Timing
- Reset values: `out`=IDLE_LEVEL, `load_ready`=1, `busy`=0, `bit_index`=0, `word_done`=0, `nack`=0, state IDLE, `hold_valid`=0.
- `reset` has priority over `abort`; `abort` has priority over everything else.
- Latency when IDLE: load accepted at edge N, `hold_valid` set at N, first bit on `out` and `busy`=1 after edge N+1.
- `load_ready` returns to 1 the cycle after the buffer transfers into `sh`.
- Each `shift_en` changes `out` on that edge; `out` is never combinational from inputs.
- A word occupies WIDTH+ACK_SLOT `shift_en` strobes.
- `word_done` is high for exactly one cycle, on the cycle after the final `shift_en` edge.
- Reset asserted mid-word returns all registers to their reset values on the next edge.

## Test plan
- **MSB-first send:** defaults, load 0xA5, 9 `shift_en` strobes 4 cycles apart, `ack_in`=0 sampled in ACK -> `out` sequence 1,0,1,0,0,1,0,1 then 1 (released); `word_done` pulses once; `nack`=0; `busy` drops to 0.
- **LSB-first, no ACK slot:** MSB_FIRST=0, ACK_SLOT=0, WIDTH=4, load 0x6 -> `out` 0,1,1,0; `word_done` after the 4th strobe; `nack`=0.
- **Back-to-back:** load 0x81, then load 0x7E while the first word is shifting -> `load_ready`=0 until the transfer; first bit of 0x7E (0) appears on the edge that ends the first word's ACK slot; two `word_done` pulses.
- **NACK and strobe collision:** `ack_in`=1 with `ack_sample` and `shift_en` in the same cycle -> `nack`=1; a later word with `ack_in`=0 -> `nack`=0.
- **Abort:** `abort` asserted after 3 bits of 0xFF with 0x55 buffered -> IDLE next edge, `out`=1, `load_ready`=1, no `word_done`; further `shift_en` strobes leave `out` unchanged.
- **Reset mid-word:** `reset`=0 during bit 5 -> all outputs at reset values after one edge; stray `shift_en`/`ack_sample` in IDLE have no effect.
